chunk_serial_addsub: RTL

CHUNK_SERIAL_ADDSUB -- requirements
Module: chunk_serial_addsub

---
 rtl/chunk_serial_addsub.sv | 135 +++++++++++++
 1 files changed

// File: rtl/chunk_serial_addsub.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// A start on the completion edge is chained directly into the next operation.
module chunk_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] res_full;
  logic             last;
  logic             accept;
  int               base;

  assign base = int'(idx_q) * CHUNK;
  assign last = (state_q == RUN) && (idx_q == IW'(NCHUNK - 1));

  // Completion edge doubles as an accept edge for back-to-back throughput.
  assign accept = start && ((state_q == IDLE) || last);

  always_comb begin
    csum = {1'b0, a_q[base +: CHUNK]}
         + {1'b0, b_q[base +: CHUNK]}
         + {{CHUNK{1'b0}}, carry_q};
    res_full = res_q;
    res_full[base +: CHUNK] = csum[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        res_d   = res_full;
        carry_d = csum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
          s_d     = res_full;
          cout_d  = csum[CHUNK];
          // Carry into the MSB is recovered from the MSB sum bit.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1]
                  ^ res_full[WIDTH-1] ^ csum[CHUNK];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub ? 1'b1 : cin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
